// File: rtl/psum_acc_ctrl.sv
// Partial-sum accumulation controller: drains OFIFO words and read-modify-writes
// them into PMEM, one pass per kernel position, with optional ReLU on the last pass.
module psum_acc_ctrl #(
    parameter int col       = 8,
    parameter int psum_bw   = 16,
    parameter int npix      = 16,
    parameter int nkij      = 9,
    parameter int pmem_base = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   relu_en,
    input  logic                   ofifo_valid,
    input  logic [psum_bw*col-1:0] ofifo_out,
    output logic                   ofifo_rd,
    input  logic [psum_bw*col-1:0] pmem_q,
    output logic [psum_bw*col-1:0] pmem_d,
    output logic [8:0]             pmem_addr,
    output logic                   pmem_cen,
    output logic                   pmem_wen,
    output logic                   busy,
    output logic [3:0]             kij,
    output logic                   pass_done,
    output logic                   done
);

    localparam int W     = psum_bw * col;
    localparam int PIX_W = (npix > 1) ? $clog2(npix) : 1;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(npix - 1);
    localparam logic [3:0]       KIJ_LAST = 4'(nkij - 1);

    typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, DONE} state_t;

    state_t           state;
    logic [PIX_W-1:0] pix;
    logic             relu_q;
    logic [W-1:0]     hold;
    logic [W-1:0]     d_last;
    logic [W-1:0]     result;

    // Two's complement lane add; overflow wraps by design
    function automatic logic signed [psum_bw-1:0] wrap_add(
        input logic signed [psum_bw-1:0] a,
        input logic signed [psum_bw-1:0] b
    );
        return a + b;
    endfunction

    // Negative lanes are forced to zero when clipping is enabled
    function automatic logic signed [psum_bw-1:0] relu_clip(
        input logic signed [psum_bw-1:0] x,
        input logic                      en
    );
        return (en && x[psum_bw-1]) ? '0 : x;
    endfunction

    function automatic logic [8:0] pix_addr(input logic [PIX_W-1:0] p);
        return 9'(pmem_base) + 9'(p);
    endfunction

    // Per-lane accumulate of the held OFIFO word with the PMEM read data
    always_comb begin
        logic signed [psum_bw-1:0] acc;
        acc    = '0;
        result = '0;
        for (int i = 0; i < col; i++) begin
            acc = wrap_add(hold[i*psum_bw +: psum_bw],
                           (kij != 4'd0) ? pmem_q[i*psum_bw +: psum_bw] : '0);
            result[i*psum_bw +: psum_bw] = relu_clip(acc, relu_q && (kij == KIJ_LAST));
        end
    end

    // Write data is live in WRITE (pmem_q arrives that cycle) and holds otherwise
    assign pmem_d = (state == WRITE) ? result : d_last;

    // Sequencing FSM; strobes are registered so they are high during their state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pix       <= '0;
            kij       <= '0;
            relu_q    <= 1'b0;
            hold      <= '0;
            d_last    <= '0;
            busy      <= 1'b0;
            pass_done <= 1'b0;
            done      <= 1'b0;
            ofifo_rd  <= 1'b0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
        end else begin
            pass_done <= 1'b0;
            done      <= 1'b0;
            ofifo_rd  <= 1'b0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        pix    <= '0;
                        kij    <= '0;
                        relu_q <= relu_en;
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (ofifo_valid) begin
                        ofifo_rd  <= 1'b1;
                        // The first pass overwrites, so it never reads PMEM
                        pmem_cen  <= (kij == 4'd0);
                        pmem_addr <= pix_addr(pix);
                        state     <= READ;
                    end
                end
                READ: begin
                    hold     <= ofifo_out;
                    pmem_cen <= 1'b0;
                    pmem_wen <= 1'b0;
                    state    <= WRITE;
                end
                WRITE: begin
                    d_last <= result;
                    if (pix != PIX_LAST) begin
                        pix   <= pix + 1'b1;
                        state <= WAIT;
                    end else begin
                        pass_done <= 1'b1;
                        if (kij != KIJ_LAST) begin
                            pix   <= '0;
                            kij   <= kij + 4'd1;
                            state <= WAIT;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Scoreboard bench for psum_acc_ctrl: models the OFIFO and PMEM, predicts every
// PMEM write and completion pulse from plain per-pixel sums.
`timescale 1ns/1ps
module tb_psum_acc_ctrl;

    localparam int COL = 8, BW = 16, NPIX = 16, NKIJ = 9, W = COL * BW;

    logic         clk = 1'b0;
    logic         reset, start, relu_en, ofifo_valid, ofifo_rd;
    logic         pmem_cen, pmem_wen, busy, pass_done, done;
    logic [W-1:0] ofifo_out, pmem_q, pmem_d;
    logic [8:0]   pmem_addr;
    logic [3:0]   kij;

    psum_acc_ctrl #(.col(COL), .psum_bw(BW), .npix(NPIX), .nkij(NKIJ), .pmem_base(0)) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
        .pmem_q(pmem_q), .pmem_d(pmem_d), .pmem_addr(pmem_addr),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .busy(busy), .kij(kij),
        .pass_done(pass_done), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int k; logic [W-1:0] data;} wr_t;

    wr_t          exp_wr[$];
    int           exp_ev[$];   // 0 = pass_done, 1 = done
    logic [W-1:0] fq[$];       // OFIFO contents
    logic [W-1:0] sram[0:511];

    int n_checks = 0, n_fail = 0, cyc = 0, n_writes = 0;
    int last_wr = 0, first_rd = -1, stall_cnt = 0;
    int tile_pops = 0, tile_pass = 0, tile_dones = 0, tile_reads = 0, reads_k0 = 0;
    bit tile_done = 0, tile_stalls = 0, rd_seen = 0;

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic void chki(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor + OFIFO/PMEM models, all sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            fq.delete(); exp_wr.delete(); exp_ev.delete();
            stall_cnt = 0; rd_seen = 0; ofifo_valid = 1'b0; ofifo_out = '0;
        end else begin
            if (stall_cnt > 0) begin
                chki("stall_ofifo_rd", int'(ofifo_rd), 0);
                chki("stall_pmem_cen", int'(pmem_cen), 1);
                stall_cnt--;
            end
            if (!pmem_cen && !pmem_wen) begin
                n_writes++;
                last_wr = cyc;
                if (exp_wr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %h, required no write", pmem_addr, pmem_d);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chki("wr_addr", int'(pmem_addr), e.addr);
                    chki("wr_kij", int'(kij), e.k);
                    chk("wr_data", pmem_d, e.data);
                end
                sram[pmem_addr] = pmem_d;
                if (tile_stalls && $urandom_range(0, 4) == 0) stall_cnt = 3;
            end
            if (!pmem_cen && pmem_wen) begin
                tile_reads++;
                if (kij == 4'd0) reads_k0++;
                pmem_q = sram[pmem_addr];
            end
            if (ofifo_rd) begin
                tile_pops++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (pass_done) begin
                tile_pass++;
                chki("pass_done_latency", cyc, last_wr + 1);
                if (exp_ev.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pass_done_event: got pulse, required none");
                end else chki("pass_done_event", exp_ev.pop_front(), 0);
            end
            if (done) begin
                tile_dones++;
                tile_done = 1;
                chki("done_latency", cyc, last_wr + 2);
                chki("done_busy_low", int'(busy), 0);
                if (exp_ev.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL done_event: got pulse, required none");
                end else chki("done_event", exp_ev.pop_front(), 1);
            end
            // The word read in READ is popped once the DUT has latched it
            if (rd_seen && fq.size() > 0) void'(fq.pop_front());
            rd_seen = ofifo_rd;
            ofifo_valid = (fq.size() > 0) && (stall_cnt == 0);
            ofifo_out   = (fq.size() > 0) ? fq[0] : '0;
        end
    end

    function automatic int lane_val(int mode, int k, int p, int l);
        case (mode)
            0: return 1;
            1: return (l == 0) ? 'hFFFF : (l == 1) ? 2 : int'($urandom_range(0, 65535));
            2: return (p == 0 && l == 2) ? ((k == 0) ? 'h7FFF : (k == 1) ? 1 : 0)
                                         : int'($urandom_range(0, 65535));
            default: return (k == 0) ? p : int'($urandom_range(0, 65535));
        endcase
    endfunction

    // Build OFIFO contents and the expected write/pulse stream for one tile
    task automatic load_tile(input int mode, input bit relu);
        int           refm [NPIX][COL];
        logic [W-1:0] word, data;
        int           v;
        for (int k = 0; k < NKIJ; k++) begin
            for (int p = 0; p < NPIX; p++) begin
                word = '0; data = '0;
                for (int l = 0; l < COL; l++) begin
                    v = lane_val(mode, k, p, l) & 'hFFFF;
                    refm[p][l] = (k == 0) ? v : ((refm[p][l] + v) & 'hFFFF);
                    if (relu && k == NKIJ - 1 && refm[p][l] >= 'h8000) refm[p][l] = 0;
                    word[l*BW +: BW] = v[BW-1:0];
                    data[l*BW +: BW] = refm[p][l][BW-1:0];
                end
                fq.push_back(word);
                exp_wr.push_back('{addr: p, k: k, data: data});
            end
            exp_ev.push_back(0);
        end
        exp_ev.push_back(1);
    endtask

    task automatic clear_tile_stats(input bit stalls);
        tile_stalls = stalls; tile_pops = 0; tile_pass = 0; tile_dones = 0;
        tile_reads = 0; reads_k0 = 0; tile_done = 0; first_rd = -1;
    endtask

    task automatic pulse_start(input bit relu);
        @(negedge clk);
        start = 1'b1; relu_en = relu;
        @(negedge clk);
        start = 1'b0; relu_en = 1'($urandom_range(0, 1));
    endtask

    task automatic run_tile(input int mode, input bit relu, input bit mid_start, input bit stalls);
        clear_tile_stats(stalls);
        load_tile(mode, relu);
        pulse_start(relu);
        for (int i = 0; i < 6000 && !tile_done; i++) begin
            @(negedge clk);
            start = (mid_start && i == 100);
        end
        start = 1'b0;
        chki("tile_completed", int'(tile_done), 1);
        chki("scoreboard_drained", exp_wr.size() + exp_ev.size(), 0);
        chki("pass_done_count", tile_pass, NKIJ);
        chki("done_count", tile_dones, 1);
        chki("ofifo_pops", tile_pops, NPIX * NKIJ);
        chki("pmem_reads", tile_reads, NPIX * (NKIJ - 1));
        chki("pmem_reads_kij0", reads_k0, 0);
        if (!stalls) chki("tile_cycles", last_wr + 1 - first_rd + 1, 3 * NPIX * NKIJ);
        @(negedge clk);
        chki("idle_busy", int'(busy), 0);
        chki("idle_done", int'(done), 0);
    endtask

    task automatic check_reset_vals();
        chki("rst_ofifo_rd", int'(ofifo_rd), 0);
        chki("rst_pmem_cen", int'(pmem_cen), 1);
        chki("rst_pmem_wen", int'(pmem_wen), 1);
        chki("rst_pmem_addr", int'(pmem_addr), 0);
        chk("rst_pmem_d", pmem_d, '0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_kij", int'(kij), 0);
        chki("rst_pass_done", int'(pass_done), 0);
        chki("rst_done", int'(done), 0);
    endtask

    initial begin
        logic [W-1:0] t;
        int           bad, base;
        reset = 1'b1; start = 1'b0; relu_en = 1'b0;
        pmem_q = {4{$urandom()}};
        for (int a = 0; a < 512; a++) sram[a] = {4{$urandom()}};
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // Constant input, no stalls, stray start mid-pass
        run_tile(0, 1'b0, 1'b1, 1'b0);
        bad = 0;
        for (int p = 0; p < NPIX; p++) begin
            t = sram[p];
            for (int l = 0; l < COL; l++) if (t[l*BW +: BW] != 16'd9) bad++;
        end
        chki("const_tile_lanes_not_9", bad, 0);

        // ReLU on and off
        run_tile(1, 1'b1, 1'b0, 1'b1);
        t = sram[0];
        chki("relu_on_lane0", int'(t[15:0]), 'h0000);
        chki("relu_on_lane1", int'(t[31:16]), 'h0012);
        run_tile(1, 1'b0, 1'b0, 1'b1);
        t = sram[NPIX-1];
        chki("relu_off_lane0", int'(t[15:0]), 'hFFF7);
        chki("relu_off_lane1", int'(t[31:16]), 'h0012);

        // Random data with wrap-around on pixel 0 lane 2
        run_tile(2, 1'b0, 1'b1, 1'b1);
        t = sram[0];
        chki("wrap_lane2", int'(t[47:32]), 'h8000);

        // Reset in the middle of pass 3, pixel 7
        clear_tile_stats(1'b0);
        load_tile(2, 1'b0);
        base = n_writes;
        pulse_start(1'b0);
        for (int i = 0; i < 3000 && n_writes < base + 3 * NPIX + 7; i++) @(negedge clk);
        chki("reset_point_reached", n_writes - base, 3 * NPIX + 7);
        #7;
        chki("pre_reset_kij", int'(kij), 3);
        reset = 1'b1;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base = n_writes;
        repeat (12) @(negedge clk);
        chki("no_write_after_reset", n_writes - base, 0);
        chki("post_reset_busy", int'(busy), 0);
        chki("post_reset_cen", int'(pmem_cen), 1);

        // First pass ramp pattern after the abandoned tile
        run_tile(3, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        run_tile(2, 1'($urandom_range(0, 1)), 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
